// File: rtl/call_stack_predictor.sv
// Return-address stack for the frontend predictor: pushes on calls, predicts
// return targets one cycle after a pop, with pointer snapshot/restore and flush.
module call_stack_predictor #(
    parameter int DEPTH    = 16,
    parameter int IP_WIDTH = 48,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_en,
    input  logic                pushCallStack,
    input  logic                popCallStack,
    input  logic [IP_WIDTH-1:0] push_IP,
    input  logic                flush,
    input  logic                restore_en,
    input  logic [PTR_W-1:0]    restore_ptr,
    input  logic [PTR_W:0]      restore_cnt,
    output logic [PTR_W-1:0]    cur_ptr,
    output logic [PTR_W:0]      cur_cnt,
    output logic                ret_valid,
    output logic [IP_WIDTH-1:0] ret_target,
    output logic                underflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    logic [IP_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W:0]      cnt;

    logic                stack_op;
    logic                empty;
    logic                wr_en;
    logic [PTR_W-1:0]    wr_addr;

    function automatic logic [PTR_W:0] sat_inc(input logic [PTR_W:0] c);
        return (c >= FULL_CNT) ? FULL_CNT : c + CNT_ONE;
    endfunction

    function automatic logic [PTR_W:0] sat_clamp(input logic [PTR_W:0] c);
        return (c > FULL_CNT) ? FULL_CNT : c;
    endfunction

    // push/pop only reach the stack when no higher-priority action is active
    assign stack_op = !flush && !restore_en && dec_en;
    assign empty    = (cnt == '0);
    assign wr_en    = stack_op && pushCallStack;
    // push+pop on a non-empty stack replaces the top in place
    assign wr_addr  = (popCallStack && !empty) ? ptr : ptr + PTR_ONE;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= push_IP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cnt        <= '0;
            ret_valid  <= 1'b0;
            ret_target <= '0;
            underflow  <= 1'b0;
        end else if (flush) begin
            ptr       <= '0;
            cnt       <= '0;
            ret_valid <= 1'b0;
            underflow <= 1'b0;
        end else if (restore_en) begin
            ptr       <= restore_ptr;
            cnt       <= sat_clamp(restore_cnt);
            ret_valid <= 1'b0;
            underflow <= 1'b0;
        end else if (!dec_en) begin
            ret_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ret_valid <= 1'b0;
            underflow <= 1'b0;
            if (popCallStack && !empty) begin
                ret_target <= mem[ptr];
                ret_valid  <= 1'b1;
                if (!pushCallStack) begin
                    ptr <= ptr - PTR_ONE;
                    cnt <= cnt - CNT_ONE;
                end
            end else begin
                // empty-stack pop flags underflow; a paired push still lands
                underflow <= popCallStack;
                if (pushCallStack) begin
                    ptr <= ptr + PTR_ONE;
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

    assign cur_ptr = ptr;
    assign cur_cnt = cnt;

endmodule

// File: tb/tb_call_stack_predictor.sv
// Scoreboard bench for call_stack_predictor: a behavioural stack model queues
// the expected registered outputs per driven cycle; directed checks add constants.
module tb_call_stack_predictor;

    localparam int DEPTH = 16;
    localparam int IPW   = 48;
    localparam int PW    = 4;

    logic           clk = 1'b0;
    logic           rst, dec_en, push_call, pop_call, flush, restore_en;
    logic [IPW-1:0] push_ip;
    logic [PW-1:0]  restore_ptr;
    logic [PW:0]    restore_cnt;
    logic [PW-1:0]  cur_ptr;
    logic [PW:0]    cur_cnt;
    logic           ret_valid, underflow;
    logic [IPW-1:0] ret_target;

    typedef struct {
        logic           rv;
        logic           uf;
        logic [IPW-1:0] rt;
        logic [PW-1:0]  p;
        logic [PW:0]    c;
    } exp_t;

    exp_t exp_q[$];

    logic [IPW-1:0] m_mem [DEPTH];
    logic [PW-1:0]  m_ptr;
    logic [PW:0]    m_cnt;
    logic           m_rv, m_uf;
    logic [IPW-1:0] m_rt;

    int n_chk  = 0;
    int n_pass = 0;

    call_stack_predictor #(.DEPTH(DEPTH), .IP_WIDTH(IPW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_en       (dec_en),
        .pushCallStack(push_call),
        .popCallStack (pop_call),
        .push_IP      (push_ip),
        .flush        (flush),
        .restore_en   (restore_en),
        .restore_ptr  (restore_ptr),
        .restore_cnt  (restore_cnt),
        .cur_ptr      (cur_ptr),
        .cur_cnt      (cur_cnt),
        .ret_valid    (ret_valid),
        .ret_target   (ret_target),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model(input logic r, input logic d, input logic pu, input logic po,
                         input logic [IPW-1:0] ip, input logic fl, input logic re,
                         input logic [PW-1:0] rp, input logic [PW:0] rc);
        if (r) begin
            m_ptr = '0; m_cnt = '0; m_rv = 0; m_uf = 0; m_rt = '0;
        end else if (fl) begin
            m_ptr = '0; m_cnt = '0; m_rv = 0; m_uf = 0;
        end else if (re) begin
            m_ptr = rp; m_cnt = (rc > 5'd16) ? 5'd16 : rc; m_rv = 0; m_uf = 0;
        end else if (!d || (!pu && !po)) begin
            m_rv = 0; m_uf = 0;
        end else if (po && m_cnt != 0) begin
            m_rt = m_mem[m_ptr]; m_rv = 1; m_uf = 0;
            if (pu) m_mem[m_ptr] = ip;
            else begin m_ptr = m_ptr - 1'b1; m_cnt = m_cnt - 1'b1; end
        end else begin
            m_rv = 0; m_uf = po;
            if (pu) begin
                m_ptr = m_ptr + 1'b1;
                m_mem[m_ptr] = ip;
                if (m_cnt < 5'd16) m_cnt = m_cnt + 1'b1;
            end
        end
    endtask

    // Drive one cycle at the falling edge, then compare at the next falling edge
    task automatic step(input logic r, input logic d, input logic pu, input logic po,
                        input logic [IPW-1:0] ip, input logic fl, input logic re,
                        input logic [PW-1:0] rp, input logic [PW:0] rc);
        exp_t e;
        rst = r; dec_en = d; push_call = pu; pop_call = po; push_ip = ip;
        flush = fl; restore_en = re; restore_ptr = rp; restore_cnt = rc;
        model(r, d, pu, po, ip, fl, re, rp, rc);
        e.rv = m_rv; e.uf = m_uf; e.rt = m_rt; e.p = m_ptr; e.c = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_ret_valid", 64'(ret_valid), 64'(e.rv));
            check("sb_underflow", 64'(underflow), 64'(e.uf));
            check("sb_cur_ptr", 64'(cur_ptr), 64'(e.p));
            check("sb_cur_cnt", 64'(cur_cnt), 64'(e.c));
            if (e.rv) check("sb_ret_target", 64'(ret_target), 64'(e.rt));
        end
    endtask

    task automatic do_push(input logic [IPW-1:0] ip);
        step(0, 1, 1, 0, ip, 0, 0, '0, '0);
    endtask

    task automatic do_pop();
        step(0, 1, 0, 1, '0, 0, 0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] sp;
        logic [PW:0]   sc;
        @(negedge clk);
        step(1, 0, 0, 0, '0, 0, 0, '0, '0);
        step(1, 0, 0, 0, '0, 0, 0, '0, '0);
        check("rst_ret_target", 64'(ret_target), 64'd0);
        check("rst_cnt", 64'(cur_cnt), 64'd0);

        // 1: pop on empty stack
        do_pop();
        check("t1_valid", 64'(ret_valid), 64'd0);
        check("t1_underflow", 64'(underflow), 64'd1);
        check("t1_cnt", 64'(cur_cnt), 64'd0);
        check("t1_ptr", 64'(cur_ptr), 64'd0);

        // 2: three pushes, three pops
        do_push(48'h1000); do_push(48'h2000); do_push(48'h3000);
        do_pop(); check("t2_pop0", 64'(ret_target), 64'h3000);
        do_pop(); check("t2_pop1", 64'(ret_target), 64'h2000);
        do_pop(); check("t2_pop2", 64'(ret_target), 64'h1000);
        check("t2_cnt", 64'(cur_cnt), 64'd0);

        // 3: overflow wraps, count saturates
        for (int i = 0; i < DEPTH + 2; i++) do_push(48'h100 + 48'(i));
        check("t3_sat", 64'(cur_cnt), 64'd16);
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check("t3_pop", 64'(ret_target), 64'h111 - 64'(i));
            check("t3_valid", 64'(ret_valid), 64'd1);
        end
        do_pop();
        check("t3_underflow", 64'(underflow), 64'd1);

        // 4: snapshot / restore, same-cycle push dropped
        do_push(48'hA0);
        sp = m_ptr; sc = m_cnt;
        do_push(48'hB0); do_push(48'hC0);
        step(0, 1, 1, 0, 48'hDD, 0, 1, sp, sc);
        check("t4_cnt", 64'(cur_cnt), 64'd1);
        do_pop(); check("t4_pop", 64'(ret_target), 64'hA0);

        // 5: push+pop replaces top
        do_push(48'h10);
        step(0, 1, 1, 1, 48'h20, 0, 0, '0, '0);
        check("t5_rt", 64'(ret_target), 64'h10);
        check("t5_cnt", 64'(cur_cnt), 64'd1);
        do_pop(); check("t5_pop", 64'(ret_target), 64'h20);

        // 6: flush beats restore; dec_en=0 pop is ignored
        for (int i = 0; i < 4; i++) do_push(48'h500 + 48'(i));
        step(0, 1, 1, 0, 48'h77, 1, 1, 4'd9, 5'd3);
        check("t6_cnt", 64'(cur_cnt), 64'd0);
        check("t6_ptr", 64'(cur_ptr), 64'd0);
        do_pop(); check("t6_underflow", 64'(underflow), 64'd1);
        do_push(48'h600);
        step(0, 0, 0, 1, '0, 0, 0, '0, '0);
        check("t6_noop_cnt", 64'(cur_cnt), 64'd1);
        check("t6_noop_valid", 64'(ret_valid), 64'd0);

        // push+pop on empty stack: push lands and underflow flags
        do_pop();
        step(0, 1, 1, 1, 48'h900, 0, 0, '0, '0);
        check("pp_empty_uf", 64'(underflow), 64'd1);
        check("pp_empty_cnt", 64'(cur_cnt), 64'd1);
        do_pop(); check("pp_empty_pop", 64'(ret_target), 64'h900);

        // restore_cnt above DEPTH clamps
        step(0, 0, 0, 0, '0, 0, 1, 4'd3, 5'd31);
        check("clamp_cnt", 64'(cur_cnt), 64'd16);

        // random traffic through the model
        for (int i = 0; i < 200; i++) begin
            step(0, 1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                 48'($urandom), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 15) == 0), 4'($urandom), 5'($urandom_range(0, 16)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
